// File: rtl/rgb_fade_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_fade_sequencer
//  Description : Command-driven fader for three PWM duty channels. It accepts
//                a target colour, a step delay and a hold time over a
//                valid/ready handshake, walks each duty one LSB per tick
//                toward its target, holds the result, then pulses done.
//  Revision    : 1.0  initial release
// ============================================================================
module rgb_fade_sequencer #(
    parameter int WIDTH   = 10,
    parameter int DELAY_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [WIDTH-1:0]   cmd_r,
    input  logic [WIDTH-1:0]   cmd_g,
    input  logic [WIDTH-1:0]   cmd_b,
    input  logic [DELAY_W-1:0] cmd_step_delay,
    input  logic [DELAY_W-1:0] cmd_hold,
    output logic [WIDTH-1:0]   duty_r,
    output logic [WIDTH-1:0]   duty_g,
    output logic [WIDTH-1:0]   duty_b,
    output logic               busy,
    output logic               done
);

    // Sequencer states
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_FADE = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;

    localparam int NUM_CH = 3;

    localparam logic [WIDTH-1:0]   c_W_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DELAY_W-1:0] c_D_ONE = {{(DELAY_W-1){1'b0}}, 1'b1};
    localparam logic [DELAY_W-1:0] c_D_ZERO = '0;

    // Registered state
    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_duty   [NUM_CH];
    logic [WIDTH-1:0]   r_target [NUM_CH];
    logic [DELAY_W-1:0] r_delay;
    logic [DELAY_W-1:0] r_hold;
    logic [DELAY_W-1:0] r_tick;
    logic [DELAY_W-1:0] r_hold_cnt;
    logic               r_cmd_ready;
    logic               r_busy;
    logic               r_done;

    // Combinational helpers
    logic [WIDTH-1:0]   w_cmd_tgt  [NUM_CH];
    logic [WIDTH-1:0]   w_step_val [NUM_CH];
    logic [NUM_CH-1:0]  w_at_target;
    logic               w_all_at_target;
    logic [DELAY_W-1:0] w_delay_eff;
    logic [DELAY_W-1:0] w_hold_eff;
    logic               w_tick_wrap;
    logic               w_hold_last;
    logic               w_accept;

    assign w_cmd_tgt[0] = cmd_r;
    assign w_cmd_tgt[1] = cmd_g;
    assign w_cmd_tgt[2] = cmd_b;

    // A zero delay or hold is treated as a single cycle.
    assign w_delay_eff = (cmd_step_delay == c_D_ZERO) ? c_D_ONE : cmd_step_delay;
    assign w_hold_eff  = (cmd_hold == c_D_ZERO)       ? c_D_ONE : cmd_hold;

    assign w_tick_wrap     = (r_tick == (r_delay - c_D_ONE));
    assign w_hold_last     = (r_hold_cnt == (r_hold - c_D_ONE));
    assign w_all_at_target = &w_at_target;
    assign w_accept        = cmd_valid && r_cmd_ready;

    // Per-channel one-LSB move toward the latched target; never overshoots.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign w_at_target[gi] = (r_duty[gi] == r_target[gi]);
            assign w_step_val[gi]  = (r_duty[gi] < r_target[gi]) ? (r_duty[gi] + c_W_ONE) :
                                     (r_duty[gi] > r_target[gi]) ? (r_duty[gi] - c_W_ONE) :
                                                                   r_duty[gi];
        end
    endgenerate

    // Main sequencer: handshake, fade stepping, hold timing and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_delay     <= '0;
            r_hold      <= '0;
            r_tick      <= '0;
            r_hold_cnt  <= '0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty[i]   <= '0;
                r_target[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            r_target[i] <= w_cmd_tgt[i];
                        end
                        r_delay     <= w_delay_eff;
                        r_hold      <= w_hold_eff;
                        r_tick      <= '0;
                        r_hold_cnt  <= '0;
                        r_state     <= c_FADE;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end

                c_FADE: begin
                    // Target check comes first so an already-reached colour
                    // moves to HOLD from the very first FADE cycle.
                    if (w_all_at_target) begin
                        r_state    <= c_HOLD;
                        r_tick     <= '0;
                        r_hold_cnt <= '0;
                    end else if (w_tick_wrap) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            r_duty[i] <= w_step_val[i];
                        end
                        r_tick <= '0;
                    end else begin
                        r_tick <= r_tick + c_D_ONE;
                    end
                end

                c_HOLD: begin
                    if (w_hold_last) begin
                        r_state     <= c_IDLE;
                        r_hold_cnt  <= '0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + c_D_ONE;
                    end
                end

                default: begin
                    r_state     <= c_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign duty_r    = r_duty[0];
    assign duty_g    = r_duty[1];
    assign duty_b    = r_duty[2];

endmodule
`default_nettype wire

// File: tb/tb_rgb_fade_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb_fade_sequencer
//  Description : Directed, table-driven bench for rgb_fade_sequencer with
//                hand-written sequences for the multi-cycle corner cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rgb_fade_sequencer;

    localparam int WIDTH   = 10;
    localparam int DELAY_W = 24;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [WIDTH-1:0]   cmd_r, cmd_g, cmd_b;
    logic [DELAY_W-1:0] cmd_step_delay, cmd_hold;
    logic [WIDTH-1:0]   duty_r, duty_g, duty_b;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rgb_fade_sequencer #(.WIDTH(WIDTH), .DELAY_W(DELAY_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_r          (cmd_r),
        .cmd_g          (cmd_g),
        .cmd_b          (cmd_b),
        .cmd_step_delay (cmd_step_delay),
        .cmd_hold       (cmd_hold),
        .duty_r         (duty_r),
        .duty_g         (duty_g),
        .duty_b         (duty_b),
        .busy           (busy),
        .done           (done)
    );

    typedef struct {
        logic [WIDTH-1:0]   r, g, b;
        logic [DELAY_W-1:0] d, h;
        int                 exp_cyc;
        logic [WIDTH-1:0]   er, eg, eb;
    } vec_t;

    vec_t vecs[6];

    // Expected trace of the first fade {r=4,g=0,b=2,D=3,H=2}, cycles a+1..a+16
    int exp_r2[16] = '{0,0,0,1,1,1,2,2,2,3,3,3,4,4,4,4};
    int exp_b2[16] = '{0,0,0,1,1,1,2,2,2,2,2,2,2,2,2,2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Present a command in the current IDLE cycle and pass its accept edge.
    task automatic send(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] g,
                        input logic [WIDTH-1:0] b, input logic [DELAY_W-1:0] d,
                        input logic [DELAY_W-1:0] h);
        cmd_r = r; cmd_g = g; cmd_b = b; cmd_step_delay = d; cmd_hold = h;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Count cycles after the accept edge until done is seen, with a budget.
    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < budget);
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int cyc;
        logic bad;

        vecs[0] = '{10'd1,    10'd0, 10'd0, 24'd1, 24'd1,    6, 10'd1,    10'd0, 10'd0};
        vecs[1] = '{10'd0,    10'd0, 10'd0, 24'd1, 24'd1,    4, 10'd0,    10'd0, 10'd0};
        vecs[2] = '{10'd1023, 10'd0, 10'd0, 24'd0, 24'd0, 1026, 10'd1023, 10'd0, 10'd0};
        vecs[3] = '{10'd1023, 10'd0, 10'd0, 24'd5, 24'd3,    5, 10'd1023, 10'd0, 10'd0};
        vecs[4] = '{10'd1000, 10'd7, 10'd9, 24'd2, 24'd1,   49, 10'd1000, 10'd7, 10'd9};
        vecs[5] = '{10'd0,    10'd0, 10'd0, 24'd1, 24'd4, 1006, 10'd0,    10'd0, 10'd0};

        rst = 1'b1; cmd_valid = 1'b0;
        cmd_r = '0; cmd_g = '0; cmd_b = '0; cmd_step_delay = '0; cmd_hold = '0;

        // Reset for two cycles
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_duty_r", duty_r, 0);
        chk("rst_duty_g", duty_g, 0);
        chk("rst_duty_b", duty_b, 0);
        chk("rst_ready",  cmd_ready, 1);
        chk("rst_busy",   busy, 0);
        chk("rst_done",   done, 0);
        rst = 1'b0;
        @(negedge clk);

        // First fade traced cycle by cycle
        send(10'd4, 10'd0, 10'd2, 24'd3, 24'd2);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            chk($sformatf("t2_r_c%0d", c), duty_r, exp_r2[c-1]);
            chk($sformatf("t2_b_c%0d", c), duty_b, exp_b2[c-1]);
            chk($sformatf("t2_g_c%0d", c), duty_g, 0);
            chk($sformatf("t2_done_c%0d", c), done, (c == 16));
            chk($sformatf("t2_busy_c%0d", c), busy, (c != 16));
            chk($sformatf("t2_ready_c%0d", c), cmd_ready, (c == 16));
        end

        // Table: each command issued back-to-back in the previous done cycle
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].d, vecs[i].h);
            wait_done(2000, cyc);
            chk($sformatf("v%0d_latency", i), cyc, vecs[i].exp_cyc);
            chk($sformatf("v%0d_r", i), duty_r, vecs[i].er);
            chk($sformatf("v%0d_g", i), duty_g, vecs[i].eg);
            chk($sformatf("v%0d_b", i), duty_b, vecs[i].eb);
            chk($sformatf("v%0d_busy", i), busy, 0);
            chk($sformatf("v%0d_ready", i), cmd_ready, 1);
        end

        // Command A {3,3,3,D=2,H=2}; command B held on the bus during A
        send(10'd3, 10'd3, 10'd3, 24'd2, 24'd2);
        cmd_r = 10'd5; cmd_g = 10'd6; cmd_b = 10'd7; cmd_step_delay = 24'd1; cmd_hold = 24'd1;
        cmd_valid = 1'b1;
        bad = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        chk("t5_not_ready_in_fade", bad, 0);
        @(negedge clk);
        chk("t5_done_a10", done, 1);
        chk("t5_ready_a10", cmd_ready, 1);
        chk("t5_r_no_latch", duty_r, 3);
        chk("t5_b_no_latch", duty_b, 3);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("t5_b_busy", busy, 1);
        chk("t5_b_start_r", duty_r, 3);
        @(negedge clk);
        chk("t5_b_step1_g", duty_g, 4);
        wait_done(50, cyc);
        chk("t5_b_latency", cyc, 5);
        chk("t5_b_final_r", duty_r, 5);
        chk("t5_b_final_g", duty_g, 6);
        chk("t5_b_final_b", duty_b, 7);

        // Reset back to zero, then abort a fade toward r=8 at duty_r=2
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_pre_r", duty_r, 0);
        send(10'd8, 10'd0, 10'd0, 24'd2, 24'd1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (duty_r !== 10'd2 && cyc < 20);
        chk("t6_reach_2_cycle", cyc, 5);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_abort_r", duty_r, 0);
        chk("t6_abort_ready", cmd_ready, 1);
        chk("t6_abort_busy", busy, 0);
        chk("t6_abort_done", done, 0);
        bad = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || duty_r !== 10'd0 || busy !== 1'b0) bad = 1'b1;
        end
        chk("t6_stays_idle", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
